// File: rtl/note_sprite_renderer.sv
// Note sprite renderer: hit-tests the current scan position against a
// double-buffered table of note boxes, addresses a 1-cycle sprite ROM and
// produces a pixel-on flag aligned with a delayed video_on.
//
// Streaming contract: one pixel enters per clock and one result leaves per
// clock, 3 cycles later. There is no valid/ready pair and no back-pressure;
// shadow writes and commit requests are always accepted on the clock edge.
// commit_pending is the only piece of control state and is a module output.
module note_sprite_renderer #(
  parameter int MAX_NOTES = 8,
  parameter int SPR_W     = 20,
  parameter int SPR_H     = 30,
  parameter int ADDR_W    = 10,
  parameter int IDX_W     = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              video_on,
  input  logic              frame_start,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic              wr_enable,
  input  logic              commit_req,
  output logic              commit_pending,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_pixel,
  output logic              pix_on,
  output logic              pix_video_on,
  output logic [IDX_W-1:0]  pix_idx
);

  localparam logic [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic [10:0] SPR_H11 = 11'(SPR_H);

  // Note tables: shadow is written by game logic, active drives the hit test.
  logic [MAX_NOTES-1:0][9:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
  logic [MAX_NOTES-1:0]      shadow_en_q, shadow_en_d;
  logic [MAX_NOTES-1:0][9:0] active_x_q, active_x_d, active_y_q, active_y_d;
  logic [MAX_NOTES-1:0]      active_en_q, active_en_d;
  logic                      commit_pending_q, commit_pending_d;
  logic                      commit_fire;

  // Pipeline registers.
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit1_q, hit1_d, vid1_q, vid1_d;
  logic [IDX_W-1:0]  idx1_q, idx1_d;
  logic              hit2_q, hit2_d, vid2_q, vid2_d;
  logic [IDX_W-1:0]  idx2_q, idx2_d;
  logic              pix_on_q, pix_on_d, pix_video_on_q, pix_video_on_d;
  logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;

  // Stage 0 results.
  logic              hit0;
  logic [IDX_W-1:0]  idx0;
  logic [ADDR_W-1:0] addr0;
  logic [10:0]       col0, row0;

  // Shadow writes and frame-synchronous commit; the copy reads pre-write shadow.
  always_comb begin
    shadow_x_d  = shadow_x_q;
    shadow_y_d  = shadow_y_q;
    shadow_en_d = shadow_en_q;
    if (wr_en) begin
      shadow_x_d[wr_idx]  = wr_x;
      shadow_y_d[wr_idx]  = wr_y;
      shadow_en_d[wr_idx] = wr_enable;
    end
    commit_fire = frame_start & (commit_pending_q | commit_req);
    active_x_d  = commit_fire ? shadow_x_q  : active_x_q;
    active_y_d  = commit_fire ? shadow_y_q  : active_y_q;
    active_en_d = commit_fire ? shadow_en_q : active_en_q;
    if (commit_fire)     commit_pending_d = 1'b0;
    else if (commit_req) commit_pending_d = 1'b1;
    else                 commit_pending_d = commit_pending_q;
  end

  // Hit test: walk slots high to low so the lowest hitting index wins.
  // Compares use 11-bit sums so boxes near 1023 never wrap.
  always_comb begin
    hit0  = 1'b0;
    idx0  = '0;
    addr0 = '0;
    col0  = '0;
    row0  = '0;
    for (int i = MAX_NOTES - 1; i >= 0; i--) begin
      if (active_en_q[i] &&
          ({1'b0, hcount} >= {1'b0, active_x_q[i]}) &&
          ({1'b0, hcount} <  {1'b0, active_x_q[i]} + SPR_W11) &&
          ({1'b0, vcount} >= {1'b0, active_y_q[i]}) &&
          ({1'b0, vcount} <  {1'b0, active_y_q[i]} + SPR_H11)) begin
        hit0  = 1'b1;
        idx0  = IDX_W'(i);
        col0  = {1'b0, hcount} - {1'b0, active_x_q[i]};
        row0  = {1'b0, vcount} - {1'b0, active_y_q[i]};
        addr0 = ADDR_W'(row0) * ADDR_W'(SPR_W) + ADDR_W'(col0);
      end
    end
  end

  // Pipeline next-state: stage 1 addresses the ROM, stage 2 waits for it,
  // stage 3 combines ROM data with hit and video_on.
  always_comb begin
    rom_addr_d     = addr0;
    hit1_d         = hit0;
    idx1_d         = idx0;
    vid1_d         = video_on;
    hit2_d         = hit1_q;
    idx2_d         = idx1_q;
    vid2_d         = vid1_q;
    pix_on_d       = rom_pixel & hit2_q & vid2_q;
    pix_idx_d      = hit2_q ? idx2_q : '0;
    pix_video_on_d = vid2_q;
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_x_q       <= '0;
      shadow_y_q       <= '0;
      shadow_en_q      <= '0;
      active_x_q       <= '0;
      active_y_q       <= '0;
      active_en_q      <= '0;
      commit_pending_q <= 1'b0;
      rom_addr_q       <= '0;
      hit1_q           <= 1'b0;
      idx1_q           <= '0;
      vid1_q           <= 1'b0;
      hit2_q           <= 1'b0;
      idx2_q           <= '0;
      vid2_q           <= 1'b0;
      pix_on_q         <= 1'b0;
      pix_idx_q        <= '0;
      pix_video_on_q   <= 1'b0;
    end else begin
      shadow_x_q       <= shadow_x_d;
      shadow_y_q       <= shadow_y_d;
      shadow_en_q      <= shadow_en_d;
      active_x_q       <= active_x_d;
      active_y_q       <= active_y_d;
      active_en_q      <= active_en_d;
      commit_pending_q <= commit_pending_d;
      rom_addr_q       <= rom_addr_d;
      hit1_q           <= hit1_d;
      idx1_q           <= idx1_d;
      vid1_q           <= vid1_d;
      hit2_q           <= hit2_d;
      idx2_q           <= idx2_d;
      vid2_q           <= vid2_d;
      pix_on_q         <= pix_on_d;
      pix_idx_q        <= pix_idx_d;
      pix_video_on_q   <= pix_video_on_d;
    end
  end

  assign commit_pending = commit_pending_q;
  assign rom_addr       = rom_addr_q;
  assign pix_on         = pix_on_q;
  assign pix_video_on   = pix_video_on_q;
  assign pix_idx        = pix_idx_q;

endmodule

// File: tb/tb_note_sprite_renderer.sv
// Bench for note_sprite_renderer with an eighth-note sprite ROM model.
module tb_note_sprite_renderer;

  localparam int IDX_W  = 3;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [9:0]        hcount, vcount;
  logic              video_on, frame_start, wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [9:0]        wr_x, wr_y;
  logic              wr_enable, commit_req, commit_pending;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_pixel = 1'b0;
  logic              pix_on, pix_video_on;
  logic [IDX_W-1:0]  pix_idx;

  int checks = 0;
  int errors = 0;

  // Expected queues: addr entries {chk, addr}, pixel entries {chk, on, vid, idx}.
  logic [10:0] addr_q[$];
  logic [5:0]  exp_q[$];
  string       addr_name_q[$];
  string       pix_name_q[$];

  typedef struct {
    string      name;
    int         h;
    int         v;
    logic       vid;
    int         addr;
    logic       on;
    int         idx;
  } vec_t;
  vec_t vecs[9];

  note_sprite_renderer dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .frame_start(frame_start), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_enable(wr_enable),
    .commit_req(commit_req), .commit_pending(commit_pending),
    .rom_addr(rom_addr), .rom_pixel(rom_pixel), .pix_on(pix_on),
    .pix_video_on(pix_video_on), .pix_idx(pix_idx)
  );

  // Clock.
  always #5 clk = ~clk;

  // Eighth-note bitmap: stem cols 17-18 rows 0-24, flag col 19 rows 0-8,
  // head rows 18-28 cols 3-18.
  function automatic logic rom_bit(input logic [9:0] a);
    int r, c;
    if (int'(a) >= 600) return 1'b0;
    r = int'(a) / 20;
    c = int'(a) % 20;
    return ((c == 17 || c == 18) && r <= 24) || (c == 19 && r <= 8) ||
           (r >= 18 && r <= 28 && c >= 3 && c <= 18);
  endfunction

  // Synchronous sprite ROM, one cycle of latency.
  always @(posedge clk) rom_pixel <= rom_bit(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: compare matured outputs, drive the next pixel, push its expectation.
  task automatic cycle(input string name, input int h, input int v, input logic vid,
                       input logic chk, input int ea, input logic eon, input int eidx);
    logic [10:0] a;
    logic [5:0]  p;
    string       n;
    if (addr_q.size() > 0) begin
      a = addr_q.pop_front();
      n = addr_name_q.pop_front();
      if (a[10]) check({n, ".rom_addr"}, 32'(rom_addr), 32'(a[9:0]));
    end
    if (exp_q.size() == 3) begin
      p = exp_q.pop_front();
      n = pix_name_q.pop_front();
      if (p[5]) begin
        check({n, ".pix_on"}, 32'(pix_on), 32'(p[4]));
        check({n, ".pix_video_on"}, 32'(pix_video_on), 32'(p[3]));
        check({n, ".pix_idx"}, 32'(pix_idx), 32'(p[2:0]));
      end
    end
    hcount   = 10'(h);
    vcount   = 10'(v);
    video_on = vid;
    addr_q.push_back({chk, 10'(ea)});
    addr_name_q.push_back(name);
    exp_q.push_back({chk, eon, vid, 3'(eidx)});
    pix_name_q.push_back(name);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle("idle", 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic drain();
    repeat (3) idle();
  endtask

  task automatic write_slot(input int idx, input int x, input int y, input logic en);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_enable = en;
    idle();
    wr_en = 1'b0;
  endtask

  task automatic ctl(input logic req, input logic fs);
    commit_req = req; frame_start = fs;
    idle();
    commit_req = 1'b0; frame_start = 1'b0;
  endtask

  task automatic scan(input string name, input int h, input int v, input logic vid,
                      input int ea, input logic eon, input int eidx);
    cycle(name, h, v, vid, 1'b1, ea, eon, eidx);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"lit_stem",   118, 50, 1'b1, 18,  1'b1, 0};
    vecs[1] = '{"blank",      110, 50, 1'b1, 10,  1'b0, 0};
    vecs[2] = '{"head",       113, 68, 1'b1, 373, 1'b1, 0};
    vecs[3] = '{"left_miss",   99, 50, 1'b1, 0,   1'b0, 0};
    vecs[4] = '{"stem_low",   117, 74, 1'b1, 497, 1'b1, 0};
    vecs[5] = '{"right_miss", 120, 50, 1'b1, 0,   1'b0, 0};
    vecs[6] = '{"below_miss", 100, 80, 1'b1, 0,   1'b0, 0};
    vecs[7] = '{"video_off",  118, 50, 1'b0, 18,  1'b0, 0};
    vecs[8] = '{"flag",       119, 58, 1'b1, 179, 1'b1, 0};

    // Reset, with writes and a commit requested during reset to prove priority.
    reset = 1'b1; hcount = '0; vcount = '0; video_on = 1'b0;
    frame_start = 1'b1; commit_req = 1'b1;
    wr_en = 1'b1; wr_idx = '0; wr_x = 10'd100; wr_y = 10'd50; wr_enable = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.rom_addr", 32'(rom_addr), 0);
    check("reset.pix_on", 32'(pix_on), 0);
    check("reset.pix_video_on", 32'(pix_video_on), 0);
    check("reset.pix_idx", 32'(pix_idx), 0);
    check("reset.commit_pending", 32'(commit_pending), 0);
    reset = 1'b0; frame_start = 1'b0; commit_req = 1'b0; wr_en = 1'b0;
    scan("reset_prio", 118, 50, 1'b1, 0, 1'b0, 0);
    drain();

    // Slot 0 at (100,50), committed, then the vector table.
    write_slot(0, 100, 50, 1'b1);
    ctl(1'b1, 1'b0);
    check("basic.pending_set", 32'(commit_pending), 1);
    ctl(1'b0, 1'b1);
    check("basic.pending_clr", 32'(commit_pending), 0);
    for (int i = 0; i < 9; i++)
      scan(vecs[i].name, vecs[i].h, vecs[i].v, vecs[i].vid, vecs[i].addr, vecs[i].on, vecs[i].idx);
    drain();

    // Commit gating: shadow write invisible until frame_start.
    write_slot(1, 200, 100, 1'b1);
    ctl(1'b1, 1'b0);
    check("gate.pending", 32'(commit_pending), 1);
    scan("gate_before", 205, 105, 1'b1, 0, 1'b0, 0);
    drain();
    ctl(1'b0, 1'b1);
    check("gate.pending_clr", 32'(commit_pending), 0);
    scan("gate_after", 205, 105, 1'b1, 105, 1'b0, 1);
    scan("gate_lit", 217, 100, 1'b1, 17, 1'b1, 1);
    drain();

    // A write in the commit cycle stays in shadow until the next commit.
    wr_en = 1'b1; wr_idx = 3'd3; wr_x = 10'd400; wr_y = 10'd150; wr_enable = 1'b1;
    ctl(1'b1, 1'b1);
    wr_en = 1'b0;
    check("samecyc.pending", 32'(commit_pending), 0);
    scan("samecyc_miss", 418, 150, 1'b1, 0, 1'b0, 0);
    drain();
    ctl(1'b1, 1'b1);
    scan("samecyc_next", 418, 150, 1'b1, 18, 1'b1, 3);
    drain();

    // Overlap priority, repeated commit_req, frame_start without a commit.
    write_slot(2, 300, 200, 1'b1);
    write_slot(5, 300, 200, 1'b1);
    ctl(1'b1, 1'b0);
    ctl(1'b1, 1'b0);
    check("overlap.pending", 32'(commit_pending), 1);
    ctl(1'b0, 1'b1);
    check("overlap.pending_clr", 32'(commit_pending), 0);
    scan("overlap_low", 318, 200, 1'b1, 18, 1'b1, 2);
    drain();
    write_slot(2, 300, 200, 1'b0);
    ctl(1'b0, 1'b1);
    scan("overlap_nocommit", 318, 200, 1'b1, 18, 1'b1, 2);
    drain();
    ctl(1'b1, 1'b1);
    scan("overlap_slot5", 318, 200, 1'b1, 18, 1'b1, 5);
    drain();

    // Screen-edge and 1023-wrap boxes.
    write_slot(4, 630, 300, 1'b1);
    write_slot(6, 1015, 1010, 1'b1);
    ctl(1'b1, 1'b1);
    scan("edge_col9", 639, 310, 1'b1, 209, 1'b0, 4);
    scan("edge_left", 629, 310, 1'b1, 0, 1'b0, 0);
    scan("edge_vidoff", 639, 310, 1'b0, 209, 1'b0, 4);
    scan("edge_lit", 638, 318, 1'b1, 368, 1'b1, 4);
    scan("wrap_in", 1020, 1015, 1'b1, 105, 1'b0, 6);
    scan("wrap_none", 3, 1015, 1'b1, 0, 1'b0, 0);
    drain();

    // Reset during continuous hits with a commit pending.
    ctl(1'b1, 1'b0);
    repeat (4) scan("pre_reset", 118, 50, 1'b1, 18, 1'b1, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset.rom_addr", 32'(rom_addr), 0);
    check("midreset.pix_on", 32'(pix_on), 0);
    check("midreset.pix_video_on", 32'(pix_video_on), 0);
    check("midreset.pix_idx", 32'(pix_idx), 0);
    check("midreset.commit_pending", 32'(commit_pending), 0);
    addr_q.delete(); addr_name_q.delete(); exp_q.delete(); pix_name_q.delete();
    reset = 1'b0;
    repeat (4) scan("post_reset", 118, 50, 1'b1, 0, 1'b0, 0);
    ctl(1'b0, 1'b1);
    scan("post_reset_fs", 118, 50, 1'b1, 0, 1'b0, 0);
    drain();
    write_slot(0, 100, 50, 1'b1);
    ctl(1'b1, 1'b1);
    scan("rearm", 118, 50, 1'b1, 18, 1'b1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sprite_renderer.md
Name: note_sprite_renderer

Overview:
- Per-pixel renderer that places up to MAX_NOTES 20x30 note sprites on screen.
- Takes the VGA scan position, finds which enabled note box covers the current pixel, and generates the address for the 1-cycle-latency sprite ROM (addr = row*20 + col).
- Combines the returned ROM bit into a pixel-on flag, aligned with a delayed video_on, for the colour mux.
- Holds a double-buffered note table: a shadow copy written by the game logic, and an active copy committed only at frame start, so no tearing.

Parameters:
MAX_NOTES, 8, number of note slots (IDX_W = clog2(MAX_NOTES))
SPR_W, 20, sprite width in pixels
SPR_H, 30, sprite height in pixels
ADDR_W, 10, ROM address width (SPR_W*SPR_H <= 2**ADDR_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
hcount  in  10  current pixel column
vcount  in  10  current pixel row
video_on  in  1  pixel is in the visible area
frame_start  in  1  one-cycle pulse at start of vertical blank
wr_en  in  1  write one shadow slot
wr_idx  in  IDX_W  slot to write
wr_x  in  10  sprite left column
wr_y  in  10  sprite top row
wr_enable  in  1  slot enabled flag
commit_req  in  1  pulse: copy shadow to active at the next frame_start
commit_pending  out  1  commit requested, not yet applied
rom_addr  out  ADDR_W  address to sprite ROM
rom_pixel  in  1  ROM data; valid 1 cycle after rom_addr
pix_on  out  1  sprite pixel lit
pix_video_on  out  1  video_on delayed to align with pix_on
pix_idx  out  IDX_W  slot that produced pix_on

Behaviour:
Reset:
- All shadow and active enable bits cleared.
- commit_pending, rom_addr, pix_on, pix_video_on, pix_idx all 0.
- All pipeline registers cleared.
- Reset takes priority over wr_en, commit_req and frame_start in the same cycle.

Shadow writes:
- On wr_en, shadow[wr_idx] <= {wr_x, wr_y, wr_enable} at the clock edge.
- Always accepted; there is no back-pressure.

Commit:
- commit_req sets commit_pending.
- On a frame_start cycle with commit_pending=1 or commit_req=1, active <= shadow and commit_pending clears.
- The copy uses shadow contents from before any same-cycle write; a write in that cycle stays in shadow for the next commit.
- Repeated commit_req while pending has no additional effect.

Hit test (stage 0, combinational on the active table):
- Slot i hits when enabled, x_i <= hcount < x_i+SPR_W, and y_i <= vcount < y_i+SPR_H.
- Sums are computed at 11 bits, so there is no wrap near 1023 or at the screen edge.
- Lowest-index hitting slot wins.
- col = hcount - x_i, row = vcount - y_i; addr = row*SPR_W + col, truncated to ADDR_W.
- If no slot hits, addr = 0.

Pipeline (input cycle t):
- t+1:
  - rom_addr, hit1, idx1 and vid1 (video_on) registered.
- t+2:
  - ROM presents rom_pixel.
  - hit2, idx2 and vid2 registered.
- t+3:
  - pix_on <= rom_pixel & hit2 & vid2.
  - pix_idx <= hit2 ? idx2 : 0.
  - pix_video_on <= vid2.
- Total latency 3 cycles.
- Fully pipelined at one pixel per clock; no stalls.
- The active table must not change mid-frame except through commit.

Boundaries:
- video_on=0 forces pix_on=0 even if a box covers the pixel.
- A sprite partially off-screen draws only its visible part.
- Reset mid-frame: outputs are 0 from the cycle after reset is asserted, and there are no stale hits after reset deasserts.

Test Plan:
- Basic hit, pixel lit:
  - Stimulus: reset; write slot 0 (x=100, y=50, en=1); commit_req; frame_start; drive h=118, v=50, video_on=1, with the eighth-note ROM attached.
  - Required: rom_addr=18 at t+1; pix_on=1, pix_idx=0 at t+3.
- Hit on a blank sprite pixel:
  - Stimulus: same setup, h=110, v=50.
  - Required: rom_addr=10, pix_on=0.
  - Stimulus: h=113, v=68 (row 18, col 13).
  - Required: rom_addr=373, pix_on=1.
- Commit gating:
  - Stimulus: write slot 1 (x=200, y=100) and commit_req without frame_start; scan (205, 105).
  - Required: pix_on=0, commit_pending=1.
  - Stimulus: assert frame_start, rescan the pixel.
  - Required: commit_pending=0, hit registered with pix_idx=1.
- Overlap priority:
  - Stimulus: slots 2 and 5 both at (300, 200), committed; scan (318, 200).
  - Required: pix_idx=2.
  - Stimulus: disable slot 2 and commit.
  - Required: pix_idx=5.
- Edges:
  - Stimulus: slot at x=630, scan h=639, v in box.
  - Required: col=9, hit.
  - Stimulus: h=629.
  - Required: no hit, rom_addr=0.
  - Stimulus: video_on=0 on an in-box pixel.
  - Required: pix_on=0, pix_video_on=0.
- Reset mid-stream:
  - Stimulus: reset during continuous hits with commit_pending=1.
  - Required: next cycle all outputs 0 and commit_pending=0; after release, no hits until a new write, commit and frame_start.
